debounced_pio_irq: RTL
======================

// Module: debounced_pio_irq
// PURPOSE
//   Parametrised Avalon-MM parallel I/O block for the board KEY/SW/LED
//   connections. Replaces the plain input/output PIOs with one block that has
//   per-channel input synchronisation, debounce, rise/fall edge capture and a
//   maskable level IRQ to the Nios II. It also has atomic set/clear on the
//   outputs.
// PARAMETERS
//   N_IN             10     input channel count (1..32)
//   N_OUT            10     output channel count (1..32)
//   DEBOUNCE_CYCLES  50000  stable cycles required before an input change is accepted (0 = bypass)
//   CNT_W            16     debounce counter width; DEBOUNCE_CYCLES must be < 2**CNT_W
// PORTS
//   clk            in   1      system clock
//   reset          in   1      synchronous, active-high reset
//   avs_address    in   3      word address of the register
//   avs_read       in   1      read strobe
//   avs_write      in   1      write strobe
//   avs_writedata  in   32     write data
//   avs_readdata   out  32     read data, fixed read latency of 1 cycle
//   irq            out  1      level interrupt, active high
//   in_port        in   N_IN   asynchronous inputs (keys, switches)
//   out_port       out  N_OUT  registered outputs (LEDs)
// BEHAVIOUR
//   Reset (sync, clk edge with reset=1):
//     - Clears sync flops, stable inputs, counters, OUT, MASK, EDGE, RISE_EN,
//       FALL_EN, avs_readdata and irq.
//     - A reset asserted mid-debounce discards the count.
//   Input path, per channel:
//     - 2-flop synchroniser produces sync[i].
//     - If sync[i] == stable[i]: cnt[i] <= 0.
//     - Otherwise cnt[i] increments each cycle. The cycle cnt[i] equals
//       DEBOUNCE_CYCLES-1, stable[i] <= sync[i] and cnt[i] <= 0.
//     - Any glitch back to stable[i] restarts the count from 0.
//     - Latency from in_port settling to stable[i] change is
//       2 + DEBOUNCE_CYCLES cycles.
//     - DEBOUNCE_CYCLES = 0: stable[i] <= sync[i] every cycle (latency 3).
//     - An input held high through reset is reported as a rising edge once it
//       is debounced after reset.
//   Edge capture:
//     - rise[i] = stable[i] & ~stable_d[i]; fall[i] = ~stable[i] & stable_d[i].
//     - EDGE[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
//     - EDGE[i] is sticky until cleared by a write-1 to EDGE.
//     - A set and a W1C on the same bit in the same cycle: the set wins.
//   IRQ:
//     - Registered: irq <= |(EDGE & MASK).
//     - Asserts 1 cycle after the EDGE bit sets.
//     - Deasserts 1 cycle after the clearing write or the mask write.
//   Register map (word addresses):
//     0 DATA     RO   stable inputs
//     1 OUT      RW   out_port value
//     2 MASK     RW   IRQ mask
//     3 EDGE     R/W1C  edge capture
//     4 RISE_EN  RW
//     5 FALL_EN  RW
//     6 OUT_SET  WO   OUT <= OUT | wdata
//     7 OUT_CLR  WO   OUT <= OUT & ~wdata
//   Register access rules:
//     - Writes take effect on the next clk edge; out_port == OUT directly.
//     - Read: avs_readdata is valid the cycle after avs_read.
//     - avs_readdata is held when no read is issued.
//     - Addresses 6/7 read 0; bits at or above N_IN/N_OUT read 0 and ignore
//       writes.
//     - Read and write in the same cycle: the read returns the pre-write value.
// TESTING
//   1 DEBOUNCE_CYCLES=8, in_port[0] 0->1 held:
//     DATA[0]=1 exactly 10 cycles later. A 5-cycle pulse is never accepted.
//   2 Bounce 1,0,1 every 3 cycles, then hold:
//     counter restarts each bounce; DATA flips 10 cycles after the final level.
//   3 RISE_EN=1, MASK=1, key press:
//     EDGE=1, irq=1 one cycle later. Write EDGE=1: irq=0 next cycle+1.
//     Press coinciding with the W1C: EDGE stays 1.
//   4 OUT=0x0F0; OUT_SET 0x003; OUT_CLR 0x010:
//     out_port = 0x0E3; read OUT returns 0x0E3; read OUT_SET returns 0.
//   5 Reset pulsed with EDGE=1, OUT=0x3FF and cnt mid-count:
//     all outputs 0 next cycle; input held high yields a rising edge after
//     DEBOUNCE_CYCLES+2.

Source files
------------

// File: rtl/debounced_pio_irq_if.sv
// Avalon-MM slave bus bundle for debounced_pio_irq.
//   avs_address   : word address (0..7)
//   avs_read      : read strobe, data returned on avs_readdata one cycle later
//   avs_write     : write strobe
//   avs_writedata : write data
//   avs_readdata  : registered read data, held between reads
//   irq           : level interrupt to the processor, active high
interface debounced_pio_irq_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/debounced_pio_irq.sv
// Parallel I/O block with per-channel synchronisation, debounce, rise/fall
// edge capture, a maskable level interrupt and atomic set/clear of outputs.
//   clk       : system clock
//   reset     : synchronous, active-high; clears all state
//   avs       : Avalon-MM slave bus plus irq (see debounced_pio_irq_if)
//   in_port   : asynchronous inputs (keys, switches)
//   out_port  : registered outputs (LEDs), mirrors the OUT register
// Register map (word address): 0 DATA, 1 OUT, 2 MASK, 3 EDGE (W1C),
// 4 RISE_EN, 5 FALL_EN, 6 OUT_SET, 7 OUT_CLR.
module debounced_pio_irq #(
  parameter int N_IN            = 10,
  parameter int N_OUT           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  debounced_pio_irq_if.slave   avs,
  input  logic [N_IN-1:0]      in_port,
  output logic [N_OUT-1:0]     out_port
);

  localparam int DB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = DB_LAST[CNT_W-1:0];

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_RISE_EN = 3'd4;
  localparam logic [2:0] A_FALL_EN = 3'd5;
  localparam logic [2:0] A_OUT_SET = 3'd6;
  localparam logic [2:0] A_OUT_CLR = 3'd7;

  logic [N_IN-1:0]             sync1_q, sync1_d;
  logic [N_IN-1:0]             sync2_q, sync2_d;
  logic [N_IN-1:0]             stable_q, stable_d;
  logic [N_IN-1:0]             stable_dly_q, stable_dly_d;
  logic [N_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_OUT-1:0]            out_q, out_d;
  logic [N_IN-1:0]             mask_q, mask_d;
  logic [N_IN-1:0]             edge_q, edge_d;
  logic [N_IN-1:0]             rise_en_q, rise_en_d;
  logic [N_IN-1:0]             fall_en_q, fall_en_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        irq_q, irq_d;

  logic [N_IN-1:0]             wdata_in;
  logic [N_OUT-1:0]            wdata_out;
  logic [N_IN-1:0]             rise, fall, edge_set, edge_clr;
  logic                        wr_out, wr_mask, wr_edge, wr_rise, wr_fall, wr_set, wr_clr;

  // Writedata bits above the channel widths are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  assign wdata_in  = avs.avs_writedata[N_IN-1:0];
  assign wdata_out = avs.avs_writedata[N_OUT-1:0];

  always_comb begin
    wr_out  = avs.avs_write && (avs.avs_address == A_OUT);
    wr_mask = avs.avs_write && (avs.avs_address == A_MASK);
    wr_edge = avs.avs_write && (avs.avs_address == A_EDGE);
    wr_rise = avs.avs_write && (avs.avs_address == A_RISE_EN);
    wr_fall = avs.avs_write && (avs.avs_address == A_FALL_EN);
    wr_set  = avs.avs_write && (avs.avs_address == A_OUT_SET);
    wr_clr  = avs.avs_write && (avs.avs_address == A_OUT_CLR);
  end

  // Input path: two-flop synchroniser then per-channel debounce counter.
  always_comb begin
    sync1_d      = in_port;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    for (int i = 0; i < N_IN; i++) begin
      if (DEBOUNCE_CYCLES == 0) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else if (sync2_q[i] == stable_q[i]) begin
        // Any return to the accepted level restarts the count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge capture: a new edge beats a simultaneous write-1-to-clear.
  always_comb begin
    rise     = stable_q & ~stable_dly_q;
    fall     = ~stable_q & stable_dly_q;
    edge_set = (rise & rise_en_q) | (fall & fall_en_q);
    edge_clr = wr_edge ? wdata_in : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
    irq_d    = |(edge_q & mask_q);
  end

  // Register writes.
  always_comb begin
    out_d     = out_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_out)  out_d     = wdata_out;
    if (wr_set)  out_d     = out_q | wdata_out;
    if (wr_clr)  out_d     = out_q & ~wdata_out;
    if (wr_mask) mask_d    = wdata_in;
    if (wr_rise) rise_en_d = wdata_in;
    if (wr_fall) fall_en_d = wdata_in;
  end

  // Read mux samples the current register values, so a read alongside a
  // write to the same register returns the pre-write contents.
  always_comb begin
    readdata_d = readdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        A_DATA:    readdata_d = 32'(stable_q);
        A_OUT:     readdata_d = 32'(out_q);
        A_MASK:    readdata_d = 32'(mask_q);
        A_EDGE:    readdata_d = 32'(edge_q);
        A_RISE_EN: readdata_d = 32'(rise_en_q);
        A_FALL_EN: readdata_d = 32'(fall_en_q);
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  assign out_port         = out_q;
  assign avs.avs_readdata = readdata_q;
  assign avs.irq          = irq_q;

endmodule
